op_scoreboard: RTL and testbench

- Parametrised scoreboard for the 16-bit core.
- Tracks NUM_FU functional units (the first two are the adder/subtractor "mather" and the memory unit) against an NUM_REGS-entry register file.
- Sits between the decoder and the functional units. It gates issue on structural and WAW hazards, holds each unit until its operands are ready (RAW), and serialises writeback onto the register file's single write port while enforcing WAR.

---
 rtl/op_scoreboard_pkg.sv | 32 +++
 rtl/op_scoreboard_slot.sv | 68 ++++++
 rtl/op_scoreboard.sv | 146 ++++++++++++++
 tb/tb_op_scoreboard.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/op_scoreboard_pkg.sv
// Shared types for the operand scoreboard: unit FSM states, per-unit status record,
// and the owner-table encoding in which the MSB set means "no producer in flight".
package op_scoreboard_pkg;

    localparam int SB_MAX_RA_W = 6;
    localparam int SB_OWN_W    = 4;

    typedef logic [SB_MAX_RA_W-1:0] reg_idx_t;
    typedef logic [SB_OWN_W-1:0]    owner_t;

    // Unit indices never exceed 7, so bit 3 alone marks an unowned register.
    localparam owner_t OWNER_NONE = 4'h8;

    typedef enum logic [1:0] {
        FU_IDLE     = 2'd0,
        FU_WAIT_OPS = 2'd1,
        FU_EXEC     = 2'd2,
        FU_WB       = 2'd3
    } fu_state_t;

    typedef struct packed {
        fu_state_t state;
        reg_idx_t  dst;
        reg_idx_t  src0;
        reg_idx_t  src1;
        owner_t    q0;
        owner_t    q1;
        logic      r0;
        logic      r1;
    } slot_t;

endpackage

// File: rtl/op_scoreboard_slot.sv
// One functional unit's tracking slot: IDLE -> WAIT_OPS -> EXEC -> WB -> IDLE, plus operand-ready flags.
// State changes one cycle after the qualifying pulse; pulses arriving in the wrong state are dropped.
module op_scoreboard_slot
    import op_scoreboard_pkg::*;
#(
    parameter int RA_W = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_issue,
    input  logic [RA_W-1:0] i_dst,
    input  logic [RA_W-1:0] i_src0,
    input  logic [RA_W-1:0] i_src1,
    input  owner_t          i_q0,
    input  owner_t          i_q1,
    input  logic            i_r0,
    input  logic            i_r1,
    input  logic            i_read_done,
    input  logic            i_exec_done,
    input  logic            i_grant,
    input  logic            i_wb_vld,
    input  owner_t          i_wb_own,
    output slot_t           o_st
);

    slot_t r_st;
    logic  w_set_r0;
    logic  w_set_r1;

    assign w_set_r0 = i_wb_vld && (r_st.q0 == i_wb_own);
    assign w_set_r1 = i_wb_vld && (r_st.q1 == i_wb_own);
    assign o_st     = r_st;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_st <= '0;
        end else begin
            case (r_st.state)
                FU_IDLE: begin
                    if (i_issue) begin
                        r_st.state <= FU_WAIT_OPS;
                        r_st.dst   <= reg_idx_t'(i_dst);
                        r_st.src0  <= reg_idx_t'(i_src0);
                        r_st.src1  <= reg_idx_t'(i_src1);
                        r_st.q0    <= i_q0;
                        r_st.q1    <= i_q1;
                        r_st.r0    <= i_r0;
                        r_st.r1    <= i_r1;
                    end
                end
                FU_WAIT_OPS: begin
                    if (w_set_r0) r_st.r0 <= 1'b1;
                    if (w_set_r1) r_st.r1 <= 1'b1;
                    // Readiness is judged on registered flags, so a same-cycle grant does not count yet.
                    if (i_read_done && r_st.r0 && r_st.r1) r_st.state <= FU_EXEC;
                end
                FU_EXEC: begin
                    if (i_exec_done) r_st.state <= FU_WB;
                end
                FU_WB: begin
                    if (i_grant) r_st.state <= FU_IDLE;
                end
                default: r_st.state <= FU_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/op_scoreboard.sv
// Operand scoreboard: owner table, structural/WAW issue gating, WAR-checked single-port writeback arbiter.
// Outputs are combinational from state; issue_ready backpressures the decoder. OP_SCOREBOARD_DEBUG_EN adds owner readback.
module op_scoreboard
    import op_scoreboard_pkg::*;
#(
    parameter int NUM_FU   = 2,
    parameter int NUM_REGS = 8,
    parameter int RA_W     = $clog2(NUM_REGS),
    parameter int FU_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              issue_valid,
    input  logic [FU_W-1:0]   issue_fu,
    input  logic [RA_W-1:0]   issue_dst,
    input  logic [RA_W-1:0]   issue_src0,
    input  logic [RA_W-1:0]   issue_src1,
    output logic              issue_ready,
    input  logic [NUM_FU-1:0] fu_read_done,
    input  logic [NUM_FU-1:0] fu_exec_done,
    output logic [NUM_FU-1:0] fu_busy,
    output logic [NUM_FU-1:0] fu_ops_ready,
    output logic              wb_valid,
    output logic [FU_W-1:0]   wb_fu,
    output logic [RA_W-1:0]   wb_dst
`ifdef OP_SCOREBOARD_DEBUG_EN
    ,
    input  logic [RA_W-1:0]   dbg_reg,
    output logic [FU_W-1:0]   dbg_owner,
    output logic              dbg_owned
`endif
);

    localparam logic [RA_W-1:0] ZERO_REG = RA_W'(NUM_REGS - 1);

    owner_t            r_owner [NUM_REGS];
    slot_t             w_st    [NUM_FU];
    logic [NUM_FU-1:0] w_issue_sel;
    logic [NUM_FU-1:0] w_elig;
    logic [NUM_FU-1:0] w_grant;
    logic              w_tgt_idle;
    logic              w_issue;
    logic              w_src0_rdy;
    logic              w_src1_rdy;
    owner_t            w_q0;
    owner_t            w_q1;
    owner_t            w_wb_own;
    logic              w_wb_vld;
    logic [FU_W-1:0]   w_wb_fu;
    logic [RA_W-1:0]   w_wb_dst;

    always_comb begin
        w_tgt_idle = 1'b0;
        for (int u = 0; u < NUM_FU; u++) begin
            if (issue_fu == FU_W'(u)) w_tgt_idle = (w_st[u].state == FU_IDLE);
        end
    end

    assign issue_ready = w_tgt_idle &&
                         ((r_owner[issue_dst] == OWNER_NONE) || (issue_dst == ZERO_REG));
    assign w_issue     = issue_valid && issue_ready;

    // A source whose producer is granted this very cycle is already safe to read.
    assign w_q0       = r_owner[issue_src0];
    assign w_q1       = r_owner[issue_src1];
    assign w_wb_own   = owner_t'(w_wb_fu);
    assign w_src0_rdy = (w_q0 == OWNER_NONE) || (issue_src0 == ZERO_REG) || (w_wb_vld && (w_q0 == w_wb_own));
    assign w_src1_rdy = (w_q1 == OWNER_NONE) || (issue_src1 == ZERO_REG) || (w_wb_vld && (w_q1 == w_wb_own));

    for (genvar g = 0; g < NUM_FU; g++) begin : g_slot
        assign w_issue_sel[g] = w_issue && (issue_fu == FU_W'(g));

        op_scoreboard_slot #(.RA_W(RA_W)) u_slot (
            .clk         (clk),
            .reset_n     (reset_n),
            .i_issue     (w_issue_sel[g]),
            .i_dst       (issue_dst),
            .i_src0      (issue_src0),
            .i_src1      (issue_src1),
            .i_q0        (w_q0),
            .i_q1        (w_q1),
            .i_r0        (w_src0_rdy),
            .i_r1        (w_src1_rdy),
            .i_read_done (fu_read_done[g]),
            .i_exec_done (fu_exec_done[g]),
            .i_grant     (w_grant[g]),
            .i_wb_vld    (w_wb_vld),
            .i_wb_own    (w_wb_own),
            .o_st        (w_st[g])
        );

        assign fu_busy[g]      = (w_st[g].state != FU_IDLE);
        assign fu_ops_ready[g] = (w_st[g].state == FU_WAIT_OPS) && w_st[g].r0 && w_st[g].r1;
    end

    // WAR: hold a result while any waiting unit still has to read the old value of its dst.
    always_comb begin
        w_elig = '0;
        for (int u = 0; u < NUM_FU; u++) begin
            if (w_st[u].state == FU_WB) begin
                w_elig[u] = 1'b1;
                for (int f = 0; f < NUM_FU; f++) begin
                    if ((w_st[f].state == FU_WAIT_OPS) &&
                        ((w_st[f].r0 && (w_st[f].src0 == w_st[u].dst)) ||
                         (w_st[f].r1 && (w_st[f].src1 == w_st[u].dst))))
                        w_elig[u] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_grant  = '0;
        w_wb_vld = 1'b0;
        w_wb_fu  = '0;
        w_wb_dst = '0;
        for (int u = NUM_FU - 1; u >= 0; u--) begin
            if (w_elig[u]) begin
                w_grant    = '0;
                w_grant[u] = 1'b1;
                w_wb_vld   = 1'b1;
                w_wb_fu    = FU_W'(u);
                w_wb_dst   = w_st[u].dst[RA_W-1:0];
            end
        end
    end

    assign wb_valid = w_wb_vld;
    assign wb_fu    = w_wb_fu;
    assign wb_dst   = w_wb_dst;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) r_owner[r] <= OWNER_NONE;
        end else begin
            if (w_wb_vld) r_owner[w_wb_dst] <= OWNER_NONE;
            if (w_issue && (issue_dst != ZERO_REG)) r_owner[issue_dst] <= owner_t'(issue_fu);
        end
    end

`ifdef OP_SCOREBOARD_DEBUG_EN
    assign dbg_owner = r_owner[dbg_reg][FU_W-1:0];
    assign dbg_owned = (r_owner[dbg_reg] != OWNER_NONE);
`endif

endmodule

// File: tb/tb_op_scoreboard.sv
// Bench for op_scoreboard: directed cycle table, async-reset sequence, and random traffic
// checked against an instruction-level model (producer ids + completion flags).
module tb_op_scoreboard;

    localparam int NF = 2;
    localparam int NR = 8;
    localparam int RW = 3;
    localparam int FW = 1;
    localparam int ZR = NR - 1;
    localparam int MAXI = 8192;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          issue_valid;
    logic [FW-1:0] issue_fu;
    logic [RW-1:0] issue_dst, issue_src0, issue_src1;
    logic          issue_ready;
    logic [NF-1:0] fu_read_done, fu_exec_done, fu_busy, fu_ops_ready;
    logic          wb_valid;
    logic [FW-1:0] wb_fu;
    logic [RW-1:0] wb_dst;
`ifdef OP_SCOREBOARD_DEBUG_EN
    logic [RW-1:0] dbg_reg;
    logic [FW-1:0] dbg_owner;
    logic          dbg_owned;
    assign dbg_reg = '0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    op_scoreboard #(.NUM_FU(NF), .NUM_REGS(NR)) dut (
        .clk(clk), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_fu(issue_fu), .issue_dst(issue_dst),
        .issue_src0(issue_src0), .issue_src1(issue_src1), .issue_ready(issue_ready),
        .fu_read_done(fu_read_done), .fu_exec_done(fu_exec_done),
        .fu_busy(fu_busy), .fu_ops_ready(fu_ops_ready),
        .wb_valid(wb_valid), .wb_fu(wb_fu), .wb_dst(wb_dst)
`ifdef OP_SCOREBOARD_DEBUG_EN
        , .dbg_reg(dbg_reg), .dbg_owner(dbg_owner), .dbg_owned(dbg_owned)
`endif
    );

    // ---------------- reference model: instructions, their producers and completion ----------------
    int m_phase [NF];   // 0 free, 1 waiting operands, 2 executing, 3 result pending
    int m_id    [NF];
    int q_dst [MAXI];
    int q_s0  [MAXI];
    int q_s1  [MAXI];
    int q_p0  [MAXI];
    int q_p1  [MAXI];
    bit q_done[MAXI];
    int n_id;

    function automatic void m_reset();
        for (int u = 0; u < NF; u++) begin m_phase[u] = 0; m_id[u] = 0; end
        n_id = 0;
    endfunction

    function automatic bit m_rdy(int p);
        return (p < 0) || q_done[p];
    endfunction

    function automatic bit m_ops(int u);
        return (m_phase[u] == 1) && m_rdy(q_p0[m_id[u]]) && m_rdy(q_p1[m_id[u]]);
    endfunction

    function automatic int m_grant();
        for (int u = 0; u < NF; u++) begin
            if (m_phase[u] == 3) begin
                bit blocked = 1'b0;
                for (int f = 0; f < NF; f++) begin
                    if (m_phase[f] == 1) begin
                        int k = m_id[f];
                        if ((q_s0[k] == q_dst[m_id[u]] && m_rdy(q_p0[k])) ||
                            (q_s1[k] == q_dst[m_id[u]] && m_rdy(q_p1[k])))
                            blocked = 1'b1;
                    end
                end
                if (!blocked) return u;
            end
        end
        return -1;
    endfunction

    function automatic bit m_issue_ok(int fu, int d);
        if (m_phase[fu] != 0) return 1'b0;
        if (d == ZR) return 1'b1;
        for (int u = 0; u < NF; u++)
            if (m_phase[u] != 0 && q_dst[m_id[u]] == d) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_prod(int s, int g);
        if (s == ZR) return -1;
        for (int u = 0; u < NF; u++)
            if (m_phase[u] != 0 && u != g && q_dst[m_id[u]] == s) return m_id[u];
        return -1;
    endfunction

    function automatic logic [9:0] m_vec(int fu, int d);
        logic [1:0]    bz, op;
        logic          wv;
        logic [FW-1:0] wf;
        logic [RW-1:0] wd;
        int            g;
        bz = '0; op = '0;
        for (int u = 0; u < NF; u++) begin
            bz[u] = (m_phase[u] != 0);
            op[u] = m_ops(u);
        end
        g  = m_grant();
        wv = (g >= 0);
        wf = '0; wd = '0;
        if (wv) begin wf = FW'(g); wd = RW'(q_dst[m_id[g]]); end
        return {m_issue_ok(fu, d), bz, op, wv, wf, wd};
    endfunction

    function automatic void m_step(bit iv, int fu, int d, int s0, int s1, logic [1:0] rd, logic [1:0] ed);
        int g  = m_grant();
        bit ok = iv && m_issue_ok(fu, d);
        int p0 = m_prod(s0, g);
        int p1 = m_prod(s1, g);
        for (int u = 0; u < NF; u++) begin
            if (m_phase[u] == 1 && rd[u] && m_ops(u)) m_phase[u] = 2;
            else if (m_phase[u] == 2 && ed[u])         m_phase[u] = 3;
        end
        if (g >= 0) begin m_phase[g] = 0; q_done[m_id[g]] = 1'b1; end
        if (ok && n_id < MAXI) begin
            q_dst[n_id] = d; q_s0[n_id] = s0; q_s1[n_id] = s1;
            q_p0[n_id] = p0; q_p1[n_id] = p1; q_done[n_id] = 1'b0;
            m_id[fu] = n_id; m_phase[fu] = 1; n_id++;
        end
    endfunction

    // ---------------- stimulus / checking helpers ----------------
    task automatic drive(bit iv, int fu, int d, int s0, int s1, logic [1:0] rd, logic [1:0] ed);
        issue_valid  = iv;
        issue_fu     = FW'(fu);
        issue_dst    = RW'(d);
        issue_src0   = RW'(s0);
        issue_src1   = RW'(s1);
        fu_read_done = rd;
        fu_exec_done = ed;
    endtask

    function automatic logic [9:0] dut_vec();
        return {issue_ready, fu_busy, fu_ops_ready, wb_valid, wb_fu, wb_dst};
    endfunction

    // vector layout: issue_ready | fu_busy[1:0] | fu_ops_ready[1:0] | wb_valid | wb_fu | wb_dst[2:0]
    task automatic check(string nm, int idx, logic [9:0] got, logic [9:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] rdy|busy|ops|wbv|wbfu|wbdst got=%b required=%b", nm, idx, got, exp);
        end
    endtask

    typedef struct {
        bit         iv;
        int         fu, d, s0, s1;
        logic [1:0] rd, ed;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl [31];

    function automatic vec_t mk(bit iv, int fu, int d, int s0, int s1, logic [1:0] rd, logic [1:0] ed,
                                logic ir, logic [1:0] bz, logic [1:0] op, logic wv, logic wf, logic [2:0] wd);
        vec_t v;
        v.iv = iv; v.fu = fu; v.d = d; v.s0 = s0; v.s1 = s1; v.rd = rd; v.ed = ed;
        v.exp = {ir, bz, op, wv, wf, wd};
        return v;
    endfunction

    initial begin
        // round trip
        tbl[0]  = mk(1,0,1,2,3,2'b00,2'b00, 1,2'b00,2'b00,0,0,0);
        tbl[1]  = mk(0,0,0,0,0,2'b01,2'b00, 0,2'b01,2'b01,0,0,0);
        tbl[2]  = mk(0,0,0,0,0,2'b00,2'b01, 0,2'b01,2'b00,0,0,0);
        tbl[3]  = mk(0,0,0,0,0,2'b00,2'b00, 0,2'b01,2'b00,1,0,1);
        // RAW on r1, then WAW on r4 (including refusal during r4's own writeback cycle)
        tbl[4]  = mk(1,0,1,2,3,2'b00,2'b00, 1,2'b00,2'b00,0,0,0);
        tbl[5]  = mk(1,1,4,1,2,2'b01,2'b00, 1,2'b01,2'b01,0,0,0);
        tbl[6]  = mk(0,0,0,0,0,2'b00,2'b01, 0,2'b11,2'b00,0,0,0);
        tbl[7]  = mk(0,0,0,0,0,2'b00,2'b00, 0,2'b11,2'b00,1,0,1);
        tbl[8]  = mk(1,0,4,0,0,2'b10,2'b00, 0,2'b10,2'b10,0,0,0);
        tbl[9]  = mk(1,0,4,0,0,2'b00,2'b10, 0,2'b10,2'b00,0,0,0);
        tbl[10] = mk(1,0,4,0,0,2'b00,2'b00, 0,2'b10,2'b00,1,1,4);
        // WAR on r5: fu1 (earlier) must read before fu0 writes
        tbl[11] = mk(1,1,6,5,0,2'b00,2'b00, 1,2'b00,2'b00,0,0,0);
        tbl[12] = mk(1,0,5,4,3,2'b00,2'b00, 1,2'b10,2'b10,0,0,0);
        tbl[13] = mk(0,0,0,0,0,2'b01,2'b00, 0,2'b11,2'b11,0,0,0);
        tbl[14] = mk(0,0,0,0,0,2'b00,2'b01, 0,2'b11,2'b10,0,0,0);
        tbl[15] = mk(0,0,0,0,0,2'b10,2'b00, 0,2'b11,2'b10,0,0,0);
        tbl[16] = mk(0,0,0,0,0,2'b00,2'b10, 0,2'b11,2'b00,1,0,5);
        tbl[17] = mk(0,0,0,0,0,2'b00,2'b00, 1,2'b10,2'b00,1,1,6);
        // both units in WB together
        tbl[18] = mk(1,0,2,0,0,2'b00,2'b00, 1,2'b00,2'b00,0,0,0);
        tbl[19] = mk(1,1,3,0,0,2'b01,2'b00, 1,2'b01,2'b01,0,0,0);
        tbl[20] = mk(0,0,0,0,0,2'b10,2'b00, 0,2'b11,2'b10,0,0,0);
        tbl[21] = mk(0,0,0,0,0,2'b00,2'b11, 0,2'b11,2'b00,0,0,0);
        tbl[22] = mk(0,0,0,0,0,2'b00,2'b00, 0,2'b11,2'b00,1,0,2);
        tbl[23] = mk(0,0,0,0,0,2'b00,2'b00, 1,2'b10,2'b00,1,1,3);
        // discard register r7
        tbl[24] = mk(1,0,7,7,7,2'b00,2'b00, 1,2'b00,2'b00,0,0,0);
        tbl[25] = mk(1,1,7,7,1,2'b00,2'b00, 1,2'b01,2'b01,0,0,0);
        tbl[26] = mk(0,0,0,0,0,2'b11,2'b00, 0,2'b11,2'b11,0,0,0);
        tbl[27] = mk(0,0,0,0,0,2'b00,2'b11, 0,2'b11,2'b00,0,0,0);
        tbl[28] = mk(0,0,0,0,0,2'b00,2'b00, 0,2'b11,2'b00,1,0,7);
        tbl[29] = mk(0,0,0,0,0,2'b00,2'b00, 1,2'b10,2'b00,1,1,7);
        tbl[30] = mk(0,0,0,0,0,2'b00,2'b00, 1,2'b00,2'b00,0,0,0);

        reset_n = 1'b0;
        drive(0,0,0,0,0,2'b00,2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", 0, dut_vec(), 10'b1_00_00_0_0_000);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 31; i++) begin
            drive(tbl[i].iv, tbl[i].fu, tbl[i].d, tbl[i].s0, tbl[i].s1, tbl[i].rd, tbl[i].ed);
            @(negedge clk);
            check("table", i, dut_vec(), tbl[i].exp);
            @(posedge clk); #1;
        end

        // reset in mid-flight: fu0 in EXEC owning r1
        drive(1,0,1,2,3,2'b00,2'b00);
        @(posedge clk); #1;
        drive(0,0,1,0,0,2'b01,2'b00);
        @(posedge clk); #1;
        drive(0,0,1,0,0,2'b00,2'b00);
        @(negedge clk);
        check("pre_reset", 0, dut_vec(), 10'b0_01_00_0_0_000);
        #2 reset_n = 1'b0;
        #1 check("async_reset", 0, dut_vec(), 10'b1_00_00_0_0_000);
        @(negedge clk);
        reset_n = 1'b1;
        m_reset();
        @(posedge clk); #1;

        for (int c = 0; c < 3000; c++) begin
            bit         iv;
            int         fu, d, s0, s1;
            logic [1:0] rd, ed;
            iv = 1'($urandom_range(0, 1));
            fu = int'($urandom_range(0, NF - 1));
            d  = int'($urandom_range(0, NR - 1));
            s0 = int'($urandom_range(0, NR - 1));
            s1 = int'($urandom_range(0, NR - 1));
            rd = 2'($urandom_range(0, 3));
            ed = 2'($urandom_range(0, 3));
            drive(iv, fu, d, s0, s1, rd, ed);
            @(negedge clk);
            check("random", c, dut_vec(), m_vec(fu, d));
            m_step(iv, fu, d, s0, s1, rd, ed);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
